// File: rtl/mem_io_responder.sv
// Byte-bus responder: RAM, UART TX/RX FIFOs, cycle counter, stop flag.
// Registered read path; io space is mem_a[17:16] == 2'b11.
module mem_io_responder #(
  parameter int    RAM_ADDR_WID = 17,
  parameter int    TX_DEPTH_LOG = 4,
  parameter int    RX_DEPTH_LOG = 4,
  parameter int    FULL_MARGIN  = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_done,
  output logic        tx_overflow
);
  localparam int TXD = 1 << TX_DEPTH_LOG;
  localparam int RXD = 1 << RX_DEPTH_LOG;
  localparam int TL  = TX_DEPTH_LOG;
  localparam int RL  = RX_DEPTH_LOG;

  logic [7:0] ram [2**RAM_ADDR_WID];
  logic [7:0] tx_mem [TXD];
  logic [7:0] rx_mem [RXD];

  logic [TL:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_cnt_d;
  logic [RL:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [31:0] cnt_q, cnt_d, lat_q, lat_d;
  logic [7:0]  io_rd_q, io_rd_d, ram_rd_q, tx_byte;
  logic        sel_ram_q, sel_ram_d;
  logic        done_q, done_d, ovf_q, ovf_d, bfull_q, bfull_d;
  logic        io, io_rd, io_wr, ram_we, ram_re;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_req, tx_push, tx_pop, rx_push, rx_pop;
  logic [15:0] off;
  logic [RAM_ADDR_WID-1:0] ram_a;
  logic        unused_hi;

  assign unused_hi = ^mem_a[31:18];

  assign io     = mem_a[17:16] == 2'b11;
  assign off    = mem_a[15:0];
  assign ram_a  = mem_a[RAM_ADDR_WID-1:0];
  assign io_rd  = rdy_in && io && !mem_wr;
  assign io_wr  = rdy_in && io && mem_wr;
  assign ram_we = rdy_in && !io && mem_wr;
  assign ram_re = rdy_in && !io && !mem_wr;

  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q[TL] != tx_rp_q[TL]) &&
                    (tx_wp_q[TL-1:0] == tx_rp_q[TL-1:0]);
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q[RL] != rx_rp_q[RL]) &&
                    (rx_wp_q[RL-1:0] == rx_rp_q[RL-1:0]);

  assign tx_valid       = !tx_empty;
  assign tx_data        = tx_mem[tx_rp_q[TL-1:0]];
  assign mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = bfull_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

  always_comb begin
    tx_req  = 1'b0;
    tx_byte = mem_dout;
    done_d  = done_q;
    if (io_wr && off == 16'h0000 && mem_dout != 8'h00)
      tx_req = 1'b1;
    if (io_wr && off == 16'h0004) begin
      tx_req  = 1'b1;
      tx_byte = 8'h00;
      done_d  = 1'b1;
    end
    tx_push  = tx_req && !tx_full;
    ovf_d    = ovf_q || (tx_req && tx_full);
    tx_pop   = rdy_in && !tx_empty && tx_ready;
    tx_wp_d  = tx_wp_q + {{TL{1'b0}}, tx_push};
    tx_rp_d  = tx_rp_q + {{TL{1'b0}}, tx_pop};
    tx_cnt_d = tx_wp_d - tx_rp_d;
    // Early warning so the write already in flight still fits.
    bfull_d  = (TXD - int'(tx_cnt_d)) <= FULL_MARGIN;

    rx_push = rdy_in && rx_valid && !rx_full;
    rx_pop  = io_rd && off == 16'h0000 && !rx_empty;
    rx_wp_d = rx_wp_q + {{RL{1'b0}}, rx_push};
    rx_rp_d = rx_rp_q + {{RL{1'b0}}, rx_pop};

    cnt_d     = (rdy_in && !done_q) ? cnt_q + 32'd1 : cnt_q;
    lat_d     = lat_q;
    io_rd_d   = io_rd_q;
    sel_ram_d = sel_ram_q;
    if (ram_re) sel_ram_d = 1'b1;
    if (io_rd) begin
      sel_ram_d = 1'b0;
      unique case (off)
        16'h0000: io_rd_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q[RL-1:0]];
        16'h0004: begin
          io_rd_d = cnt_q[7:0];
          lat_d   = cnt_q;
        end
        16'h0005: io_rd_d = lat_q[15:8];
        16'h0006: io_rd_d = lat_q[23:16];
        16'h0007: io_rd_d = lat_q[31:24];
        default:  io_rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      io_rd_q   <= '0;
      sel_ram_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bfull_q   <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      io_rd_q   <= io_rd_d;
      sel_ram_q <= sel_ram_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bfull_q   <= bfull_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_a] <= mem_dout;
    if (ram_re) ram_rd_q <= ram[ram_a];
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp_q[TL-1:0]] <= tx_byte;
    if (rx_push) rx_mem[rx_wp_q[RL-1:0]] <= rx_data;
  end
endmodule
